apb_master_arbiter: RTL and testbench

- Shares one APB peripheral bus between two APB masters, e.g. the AXI-to-APB bridge (port 0) and a debug/config master (port 1).
- Performs round-robin arbitration and decodes the slave index from the master address.
- Drives the per-slave PSEL vector and watchdogs each access with a timeout that returns PSLVERR.
- Sits between the masters and the peripheral subsystem slaves.

---
 rtl/apb_master_arbiter_if.sv | 37 +++
 rtl/apb_master_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bus bundle for apb_master_arbiter: two upstream APB masters plus the shared
// downstream peripheral bus. The arbiter connects through the master modport.
interface apb_master_arbiter_if #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_WIDTH = 12
);
  logic [1:0]                  m_psel_i;
  logic [1:0]                  m_penable_i;
  logic [1:0]                  m_pwrite_i;
  logic [1:0][31:0]            m_paddr_i;
  logic [1:0][31:0]            m_pwdata_i;
  logic [1:0][31:0]            m_prdata_o;
  logic [1:0]                  m_pready_o;
  logic [1:0]                  m_pslverr_o;
  logic                        penable;
  logic                        pwrite;
  logic [ADDR_WIDTH-1:0]       paddr;
  logic [NUM_SLAVES-1:0]       psel;
  logic [31:0]                 pwdata;
  logic [NUM_SLAVES-1:0][31:0] prdata;
  logic [NUM_SLAVES-1:0]       pready;
  logic [NUM_SLAVES-1:0]       pslverr;

  modport master (
    input  m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    input  prdata, pready, pslverr,
    output m_prdata_o, m_pready_o, m_pslverr_o,
    output penable, pwrite, paddr, psel, pwdata
  );

  modport slave (
    output m_psel_i, m_penable_i, m_pwrite_i, m_paddr_i, m_pwdata_i,
    output prdata, pready, pslverr,
    input  m_prdata_o, m_pready_o, m_pslverr_o,
    input  penable, pwrite, paddr, psel, pwdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-master round-robin APB arbiter with slave-index decode, one-hot PSEL
// generation and an access watchdog that aborts stuck transfers with PSLVERR.
module apb_master_arbiter #(
  parameter int APB_NUM_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int SLV_IDX_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  apb_master_arbiter_if.master bus,
  output logic                 timeout_o
);
  localparam int SW = (APB_NUM_SLAVES > 1) ? $clog2(APB_NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  // Timeout fires during the ACCESS cycle whose pre-increment count is TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SW:0]   NUM_W   = (SW + 1)'(APB_NUM_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      rr_q, rr_d;
  logic                      g_q, g_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic [SW-1:0]             idx_q, idx_d;
  logic                      dec_err_q, dec_err_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [APB_NUM_SLAVES-1:0] psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [1:0][31:0]          m_prdata_q, m_prdata_d;
  logic [1:0]                m_pready_q, m_pready_d;
  logic [1:0]                m_pslverr_q, m_pslverr_d;
  logic                      timeout_q, timeout_d;

  logic                      k_s;
  logic [SW-1:0]             req_idx_s;
  logic                      req_err_s;
  logic                      hit_s;
  logic [31:0]               sel_rdata_s;
  logic                      sel_ready_s;
  logic                      sel_err_s;

  function automatic logic [APB_NUM_SLAVES-1:0] idx_onehot(input logic [SW-1:0] idx);
    logic [APB_NUM_SLAVES-1:0] oh;
    oh = '0;
    for (int i = 0; i < APB_NUM_SLAVES; i++) begin
      oh[i] = (idx == SW'(i));
    end
    return oh;
  endfunction

  // Next-state logic: arbitration, slave decode, completion and watchdog.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    g_d         = g_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    dec_err_d   = dec_err_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    m_prdata_d  = '0;
    m_pready_d  = 2'b00;
    m_pslverr_d = 2'b00;
    timeout_d   = 1'b0;
    k_s         = 1'b0;
    req_idx_s   = '0;
    req_err_s   = 1'b0;
    hit_s       = 1'b0;
    sel_rdata_s = 32'h0;
    sel_ready_s = 1'b0;
    sel_err_s   = 1'b0;

    for (int i = 0; i < APB_NUM_SLAVES; i++) begin
      hit_s       = (idx_q == SW'(i));
      sel_rdata_s = sel_rdata_s | ({32{hit_s}} & bus.prdata[i]);
      sel_ready_s = sel_ready_s | (hit_s & bus.pready[i]);
      sel_err_s   = sel_err_s   | (hit_s & bus.pslverr[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.m_psel_i != 2'b00) begin
          k_s       = (bus.m_psel_i == 2'b11) ? rr_q : bus.m_psel_i[1];
          req_idx_s = bus.m_paddr_i[k_s][SLV_IDX_LSB +: SW];
          req_err_s = ({1'b0, req_idx_s} >= NUM_W);
          g_d       = k_s;
          rr_d      = ~k_s;
          pwrite_d  = bus.m_pwrite_i[k_s];
          paddr_d   = bus.m_paddr_i[k_s][APB_ADDR_WIDTH-1:0];
          pwdata_d  = bus.m_pwdata_i[k_s];
          idx_d     = req_idx_s;
          dec_err_d = req_err_s;
          psel_d    = req_err_s ? '0 : idx_onehot(req_idx_s);
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = ~dec_err_q;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        // Slave ready (or decode error) wins over a coincident timeout.
        if (dec_err_q || sel_ready_s) begin
          m_prdata_d[g_q]  = dec_err_q ? 32'h0 : sel_rdata_s;
          m_pslverr_d[g_q] = dec_err_q | sel_err_s;
          m_pready_d[g_q]  = 1'b1;
          psel_d           = '0;
          penable_d        = 1'b0;
          state_d          = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          m_pslverr_d[g_q] = 1'b1;
          m_pready_d[g_q]  = 1'b1;
          timeout_d        = 1'b1;
          psel_d           = '0;
          penable_d        = 1'b0;
          state_d          = ST_RESP;
        end else begin
          state_d          = ST_ACCESS;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the bus without any completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      g_q         <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0;
      idx_q       <= '0;
      dec_err_q   <= 1'b0;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      m_prdata_q  <= '0;
      m_pready_q  <= 2'b00;
      m_pslverr_q <= 2'b00;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      g_q         <= g_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      dec_err_q   <= dec_err_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      m_prdata_q  <= m_prdata_d;
      m_pready_q  <= m_pready_d;
      m_pslverr_q <= m_pslverr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.psel        = psel_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.m_prdata_o  = m_prdata_q;
  assign bus.m_pready_o  = m_pready_q;
  assign bus.m_pslverr_o = m_pslverr_q;
  assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a default instance (8 slaves, long
// timeout) and a variant (10 slaves, TIMEOUT_CYCLES=4) driven at the negedge.
module tb_apb_master_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic timeout_a;
  logic timeout_b;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   multi_sel = 1'b0;

  apb_master_arbiter_if #(.NUM_SLAVES(8),  .ADDR_WIDTH(12)) bus_a ();
  apb_master_arbiter_if #(.NUM_SLAVES(10), .ADDR_WIDTH(12)) bus_b ();

  apb_master_arbiter #(
    .APB_NUM_SLAVES(8), .APB_ADDR_WIDTH(12), .SLV_IDX_LSB(12), .TIMEOUT_CYCLES(255)
  ) u_dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_a), .timeout_o(timeout_a));

  apb_master_arbiter #(
    .APB_NUM_SLAVES(10), .APB_ADDR_WIDTH(12), .SLV_IDX_LSB(12), .TIMEOUT_CYCLES(4)
  ) u_dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_b), .timeout_o(timeout_b));

  always #5 clk_i = ~clk_i;

  // Flag any cycle where more than one slave is selected.
  always @(negedge clk_i) begin
    if (($countones(bus_a.psel) > 1) || ($countones(bus_b.psel) > 1)) multi_sel = 1'b1;
  end

  task automatic clear_inputs();
    bus_a.m_psel_i = 2'b00; bus_a.m_penable_i = 2'b00; bus_a.m_pwrite_i = 2'b00;
    bus_a.m_paddr_i = '0; bus_a.m_pwdata_i = '0;
    bus_a.prdata = '0; bus_a.pready = '0; bus_a.pslverr = '0;
    bus_b.m_psel_i = 2'b00; bus_b.m_penable_i = 2'b00; bus_b.m_pwrite_i = 2'b00;
    bus_b.m_paddr_i = '0; bus_b.m_pwdata_i = '0;
    bus_b.prdata = '0; bus_b.pready = '0; bus_b.pslverr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_ni = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus_a.psel !== 8'h00) begin n_err++; $display("FAIL rst_psel_a: got %h expected %h", bus_a.psel, 8'h00); end
    n_cmp++; if (bus_a.penable !== 1'b0) begin n_err++; $display("FAIL rst_penable_a: got %b expected 0", bus_a.penable); end
    n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL rst_mpready_a: got %b expected 00", bus_a.m_pready_o); end
    n_cmp++; if (bus_a.m_prdata_o !== 64'h0) begin n_err++; $display("FAIL rst_mprdata_a: got %h expected 0", bus_a.m_prdata_o); end
    n_cmp++; if (bus_a.m_pslverr_o !== 2'b00) begin n_err++; $display("FAIL rst_mpslverr_a: got %b expected 00", bus_a.m_pslverr_o); end
    n_cmp++; if (bus_a.paddr !== 12'h000) begin n_err++; $display("FAIL rst_paddr_a: got %h expected 000", bus_a.paddr); end
    n_cmp++; if (timeout_a !== 1'b0) begin n_err++; $display("FAIL rst_timeout_a: got %b expected 0", timeout_a); end
    n_cmp++; if (bus_b.psel !== 10'h000) begin n_err++; $display("FAIL rst_psel_b: got %h expected 000", bus_b.psel); end
    n_cmp++; if (timeout_b !== 1'b0) begin n_err++; $display("FAIL rst_timeout_b: got %b expected 0", timeout_b); end
    @(negedge clk_i); rst_ni = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    bus_a.m_psel_i = 2'b01; bus_a.m_pwrite_i = 2'b01;
    bus_a.m_paddr_i[0] = 32'h0000_2010; bus_a.m_pwdata_i[0] = 32'hDEAD_BEEF;
    bus_a.pready = 8'h04;
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h04) begin n_err++; $display("FAIL wr_setup_psel: got %h expected %h", bus_a.psel, 8'h04); end
    n_cmp++; if (bus_a.penable !== 1'b0) begin n_err++; $display("FAIL wr_setup_penable: got %b expected 0", bus_a.penable); end
    n_cmp++; if (bus_a.paddr !== 12'h010) begin n_err++; $display("FAIL wr_paddr: got %h expected 010", bus_a.paddr); end
    n_cmp++; if (bus_a.pwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_pwdata: got %h expected deadbeef", bus_a.pwdata); end
    n_cmp++; if (bus_a.pwrite !== 1'b1) begin n_err++; $display("FAIL wr_pwrite: got %b expected 1", bus_a.pwrite); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.penable !== 1'b1) begin n_err++; $display("FAIL wr_access_penable: got %b expected 1", bus_a.penable); end
    n_cmp++; if (bus_a.psel !== 8'h04) begin n_err++; $display("FAIL wr_access_psel: got %h expected 04", bus_a.psel); end
    n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL wr_access_mpready: got %b expected 00", bus_a.m_pready_o); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b01) begin n_err++; $display("FAIL wr_resp_mpready: got %b expected 01", bus_a.m_pready_o); end
    n_cmp++; if (bus_a.m_pslverr_o !== 2'b00) begin n_err++; $display("FAIL wr_resp_pslverr: got %b expected 00", bus_a.m_pslverr_o); end
    n_cmp++; if (bus_a.psel !== 8'h00) begin n_err++; $display("FAIL wr_resp_psel: got %h expected 00", bus_a.psel); end
    n_cmp++; if (bus_a.penable !== 1'b0) begin n_err++; $display("FAIL wr_resp_penable: got %b expected 0", bus_a.penable); end
    bus_a.m_psel_i = 2'b00; bus_a.pready = 8'h00;
    @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL wr_idle_mpready: got %b expected 00", bus_a.m_pready_o); end
    n_cmp++; if (bus_a.paddr !== 12'h010) begin n_err++; $display("FAIL wr_idle_paddr_hold: got %h expected 010", bus_a.paddr); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus_a.pready = 8'hFF; bus_a.m_pwrite_i = 2'b00;
    bus_a.m_paddr_i[0] = 32'h0000_1004; bus_a.m_paddr_i[1] = 32'h0000_3008;
    bus_a.m_psel_i = 2'b11;
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h02) begin n_err++; $display("FAIL rr_first_m0: got %h expected 02", bus_a.psel); end
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b01) begin n_err++; $display("FAIL rr_first_resp: got %b expected 01", bus_a.m_pready_o); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h00) begin n_err++; $display("FAIL rr_gap1_psel: got %h expected 00", bus_a.psel); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h08) begin n_err++; $display("FAIL rr_second_m1: got %h expected 08", bus_a.psel); end
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b10) begin n_err++; $display("FAIL rr_second_resp: got %b expected 10", bus_a.m_pready_o); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h00) begin n_err++; $display("FAIL rr_gap2_psel: got %h expected 00", bus_a.psel); end
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h02) begin n_err++; $display("FAIL rr_third_m0: got %h expected 02", bus_a.psel); end
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b01) begin n_err++; $display("FAIL rr_third_resp: got %b expected 01", bus_a.m_pready_o); end
    bus_a.m_psel_i = 2'b00; bus_a.pready = 8'h00;
    @(negedge clk_i);
    n_cmp++; if (multi_sel !== 1'b0) begin n_err++; $display("FAIL rr_psel_onehot: got %b expected 0", multi_sel); end
  endtask

  task automatic test_wait_read();
    bus_a.m_psel_i = 2'b10; bus_a.m_pwrite_i = 2'b00;
    bus_a.m_paddr_i[1] = 32'h0000_500C; bus_a.prdata[5] = 32'h1234_5678; bus_a.pready = 8'h00;
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h20) begin n_err++; $display("FAIL rd_setup_psel: got %h expected 20", bus_a.psel); end
    n_cmp++; if (bus_a.paddr !== 12'h00C) begin n_err++; $display("FAIL rd_paddr: got %h expected 00c", bus_a.paddr); end
    n_cmp++; if (bus_a.pwrite !== 1'b0) begin n_err++; $display("FAIL rd_pwrite: got %b expected 0", bus_a.pwrite); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      if (c == 4) bus_a.pready = 8'h20;
      n_cmp++; if (bus_a.penable !== 1'b1) begin n_err++; $display("FAIL rd_access%0d_penable: got %b expected 1", c, bus_a.penable); end
      n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL rd_access%0d_mpready: got %b expected 00", c, bus_a.m_pready_o); end
    end
    @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b10) begin n_err++; $display("FAIL rd_resp_mpready: got %b expected 10", bus_a.m_pready_o); end
    n_cmp++; if (bus_a.m_prdata_o[1] !== 32'h1234_5678) begin n_err++; $display("FAIL rd_resp_rdata: got %h expected 12345678", bus_a.m_prdata_o[1]); end
    n_cmp++; if (bus_a.m_prdata_o[0] !== 32'h0) begin n_err++; $display("FAIL rd_other_rdata: got %h expected 0", bus_a.m_prdata_o[0]); end
    n_cmp++; if (bus_a.m_pslverr_o !== 2'b00) begin n_err++; $display("FAIL rd_resp_pslverr: got %b expected 00", bus_a.m_pslverr_o); end
    bus_a.m_psel_i = 2'b00; bus_a.pready = 8'h00;
    @(negedge clk_i);
    n_cmp++; if (bus_a.m_prdata_o[1] !== 32'h0) begin n_err++; $display("FAIL rd_idle_rdata: got %h expected 0", bus_a.m_prdata_o[1]); end
  endtask

  task automatic test_decode();
    bus_b.m_psel_i = 2'b01; bus_b.m_paddr_i[0] = 32'h0000_9000;
    bus_b.prdata[9] = 32'hCAFE_0009; bus_b.pready = 10'h3FF;
    @(negedge clk_i);
    n_cmp++; if (bus_b.psel !== 10'h200) begin n_err++; $display("FAIL dec_slave9_psel: got %h expected 200", bus_b.psel); end
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_b.m_prdata_o[0] !== 32'hCAFE_0009) begin n_err++; $display("FAIL dec_slave9_rdata: got %h expected cafe0009", bus_b.m_prdata_o[0]); end
    bus_b.m_paddr_i[0] = 32'h0000_A000;
    for (int i = 0; i < 10; i++) bus_b.prdata[i] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_b.psel !== 10'h000) begin n_err++; $display("FAIL dec_err_setup_psel: got %h expected 000", bus_b.psel); end
    @(negedge clk_i);
    n_cmp++; if (bus_b.psel !== 10'h000) begin n_err++; $display("FAIL dec_err_access_psel: got %h expected 000", bus_b.psel); end
    n_cmp++; if (bus_b.penable !== 1'b0) begin n_err++; $display("FAIL dec_err_penable: got %b expected 0", bus_b.penable); end
    @(negedge clk_i);
    n_cmp++; if (bus_b.m_pready_o !== 2'b01) begin n_err++; $display("FAIL dec_err_mpready: got %b expected 01", bus_b.m_pready_o); end
    n_cmp++; if (bus_b.m_pslverr_o !== 2'b01) begin n_err++; $display("FAIL dec_err_pslverr: got %b expected 01", bus_b.m_pslverr_o); end
    n_cmp++; if (bus_b.m_prdata_o[0] !== 32'h0) begin n_err++; $display("FAIL dec_err_rdata: got %h expected 0", bus_b.m_prdata_o[0]); end
    n_cmp++; if (timeout_b !== 1'b0) begin n_err++; $display("FAIL dec_err_timeout: got %b expected 0", timeout_b); end
    bus_b.m_psel_i = 2'b00; bus_b.pready = 10'h000;
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    bus_b.m_psel_i = 2'b10; bus_b.m_paddr_i[1] = 32'h0000_3000; bus_b.pready = 10'h000;
    @(negedge clk_i);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      n_cmp++; if (bus_b.psel !== 10'h008) begin n_err++; $display("FAIL to_access%0d_psel: got %h expected 008", c, bus_b.psel); end
      n_cmp++; if (timeout_b !== 1'b0) begin n_err++; $display("FAIL to_access%0d_timeout: got %b expected 0", c, timeout_b); end
    end
    @(negedge clk_i);
    n_cmp++; if (bus_b.psel !== 10'h000) begin n_err++; $display("FAIL to_resp_psel: got %h expected 000", bus_b.psel); end
    n_cmp++; if (timeout_b !== 1'b1) begin n_err++; $display("FAIL to_resp_pulse: got %b expected 1", timeout_b); end
    n_cmp++; if (bus_b.m_pready_o !== 2'b10) begin n_err++; $display("FAIL to_resp_mpready: got %b expected 10", bus_b.m_pready_o); end
    n_cmp++; if (bus_b.m_pslverr_o !== 2'b10) begin n_err++; $display("FAIL to_resp_pslverr: got %b expected 10", bus_b.m_pslverr_o); end
    n_cmp++; if (bus_b.m_prdata_o[1] !== 32'h0) begin n_err++; $display("FAIL to_resp_rdata: got %h expected 0", bus_b.m_prdata_o[1]); end
    bus_b.m_psel_i = 2'b00;
    @(negedge clk_i);
    n_cmp++; if (timeout_b !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b expected 0", timeout_b); end
    bus_b.m_psel_i = 2'b10; bus_b.prdata[3] = 32'h0BAD_F00D;
    @(negedge clk_i);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      if (c == 4) bus_b.pready = 10'h008;
    end
    @(negedge clk_i);
    n_cmp++; if (timeout_b !== 1'b0) begin n_err++; $display("FAIL to_late_ready_timeout: got %b expected 0", timeout_b); end
    n_cmp++; if (bus_b.m_pslverr_o !== 2'b00) begin n_err++; $display("FAIL to_late_ready_pslverr: got %b expected 00", bus_b.m_pslverr_o); end
    n_cmp++; if (bus_b.m_prdata_o[1] !== 32'h0BAD_F00D) begin n_err++; $display("FAIL to_late_ready_rdata: got %h expected 0badf00d", bus_b.m_prdata_o[1]); end
    bus_b.m_psel_i = 2'b00; bus_b.pready = 10'h000;
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    bus_a.m_psel_i = 2'b01; bus_a.m_paddr_i[0] = 32'h0000_4000; bus_a.pready = 8'h00;
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_a.penable !== 1'b1) begin n_err++; $display("FAIL rm_access_penable: got %b expected 1", bus_a.penable); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus_a.psel !== 8'h00) begin n_err++; $display("FAIL rm_psel: got %h expected 00", bus_a.psel); end
    n_cmp++; if (bus_a.penable !== 1'b0) begin n_err++; $display("FAIL rm_penable: got %b expected 0", bus_a.penable); end
    n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL rm_mpready: got %b expected 00", bus_a.m_pready_o); end
    bus_a.m_psel_i = 2'b11; bus_a.m_paddr_i[1] = 32'h0000_6000;
    @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b00) begin n_err++; $display("FAIL rm_held_mpready: got %b expected 00", bus_a.m_pready_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (bus_a.psel !== 8'h10) begin n_err++; $display("FAIL rm_regrant_m0: got %h expected 10", bus_a.psel); end
    bus_a.pready = 8'h10;
    repeat (2) @(negedge clk_i);
    n_cmp++; if (bus_a.m_pready_o !== 2'b01) begin n_err++; $display("FAIL rm_regrant_resp: got %b expected 01", bus_a.m_pready_o); end
    bus_a.m_psel_i = 2'b00; bus_a.pready = 8'h00;
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b1;
    clear_inputs();
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_write_zero_wait();
    test_round_robin();
    test_wait_read();
    test_decode();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
